// File: rtl/audio_pkg.sv
// Shared definitions for the stereo output gain stage: widths, gain format
// and the sequencer state encoding.
package audio_pkg;

  localparam int AUDIO_DW   = 16;
  localparam int GAIN_W     = 8;
  localparam int GAIN_UNITY = 128;
  localparam int GAIN_FRAC  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL_L = 2'd1,
    ST_MUL_R = 2'd2,
    ST_SAT   = 2'd3
  } gain_state_e;

endpackage

// File: rtl/audio_gain_stage_if.sv
// Sample stream bundle: strobed stereo input from fm_gen and the processed
// stereo output with its load pulse towards the I2S serializer.
interface audio_gain_stage_if
  import audio_pkg::*;
#(
  parameter int DW = AUDIO_DW
) ();

  logic                 ena_in;
  logic signed [DW-1:0] l_in;
  logic signed [DW-1:0] r_in;
  logic signed [DW-1:0] l_out;
  logic signed [DW-1:0] r_out;
  logic                 valid_out;

  modport master (
    output ena_in,
    output l_in,
    output r_in,
    input  l_out,
    input  r_out,
    input  valid_out
  );

  modport slave (
    input  ena_in,
    input  l_in,
    input  r_in,
    output l_out,
    output r_out,
    output valid_out
  );

endinterface

// File: rtl/sat_shift.sv
// Converts a Q1.7-scaled product back to sample scale (arithmetic shift,
// rounding toward minus infinity) and clamps it into the signed DW range.
module sat_shift
  import audio_pkg::*;
#(
  parameter int DW = AUDIO_DW,
  parameter int PW = AUDIO_DW + GAIN_W + 1
) (
  input  logic signed [PW-1:0] p,
  output logic signed [DW-1:0] y,
  output logic                 clip
);

  logic signed [PW-1:0] shifted;
  logic        [PW-DW:0] upper;

  assign shifted = p >>> GAIN_FRAC;
  assign upper   = shifted[PW-1:DW-1];

  // The value fits only when every bit from the DW sign position upward agrees.
  assign clip = !((&upper) || !(|upper));

  always_comb begin
    y = shifted[DW-1:0];
    if (clip) begin
      y = shifted[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/audio_gain_stage.sv
// Stereo output gain/mute stage: ramped per-channel gain, one shared
// multiplier used for L then R, saturating outputs and sticky status flags.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int DW        = AUDIO_DW,
  parameter int GW        = GAIN_W,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  audio_gain_stage_if.slave aud,
  input  logic [GW-1:0]     gain_l,
  input  logic [GW-1:0]     gain_r,
  input  logic              mute,
  input  logic              clip_clr,
  output logic              busy,
  output logic              clip_l,
  output logic              clip_r,
  output logic              overrun
);

  localparam int            PW   = DW + GW + 1;
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);

  // Move the current gain toward its target by at most STEP, never past it.
  function automatic logic [GW-1:0] ramp_toward(input logic [GW-1:0] cur,
                                                input logic [GW-1:0] tgt);
    logic [GW-1:0] nxt;
    nxt = tgt;
    if (cur < tgt) begin
      if ((tgt - cur) > STEP) nxt = cur + STEP;
    end else if ((cur - tgt) > STEP) begin
      nxt = cur - STEP;
    end
    return nxt;
  endfunction

  gain_state_e state_q, state_d;

  logic signed [DW-1:0] l_in_q, l_in_d;
  logic signed [DW-1:0] r_in_q, r_in_d;
  logic signed [DW-1:0] l_out_q, l_out_d;
  logic signed [DW-1:0] r_out_q, r_out_d;
  logic        [GW-1:0] cg_l_q, cg_l_d;
  logic        [GW-1:0] cg_r_q, cg_r_d;
  logic signed [PW-1:0] p_l_q, p_l_d;
  logic signed [PW-1:0] p_r_q, p_r_d;
  logic                 valid_q, valid_d;
  logic                 clip_l_q, clip_l_d;
  logic                 clip_r_q, clip_r_d;
  logic                 overrun_q, overrun_d;

  logic        [GW-1:0] tgt_l, tgt_r;
  logic signed [DW-1:0] mul_a;
  logic signed [GW:0]   mul_b;
  logic signed [PW-1:0] mul_p;
  logic signed [DW-1:0] sat_l_y, sat_r_y;
  logic                 sat_l_clip, sat_r_clip;

  assign tgt_l = mute ? '0 : gain_l;
  assign tgt_r = mute ? '0 : gain_r;

  // One multiplier serves both channels; the gain is zero-extended so it stays positive.
  always_comb begin
    mul_a = l_in_q;
    mul_b = $signed({1'b0, cg_l_q});
    if (state_q == ST_MUL_R) begin
      mul_a = r_in_q;
      mul_b = $signed({1'b0, cg_r_q});
    end
  end

  assign mul_p = $signed({{(GW+1){mul_a[DW-1]}}, mul_a} * {{(DW-1){mul_b[GW]}}, mul_b});

  sat_shift #(.DW(DW), .PW(PW)) u_sat_l (
    .p    (p_l_q),
    .y    (sat_l_y),
    .clip (sat_l_clip)
  );

  sat_shift #(.DW(DW), .PW(PW)) u_sat_r (
    .p    (p_r_q),
    .y    (sat_r_y),
    .clip (sat_r_clip)
  );

  always_comb begin
    state_d   = state_q;
    l_in_d    = l_in_q;
    r_in_d    = r_in_q;
    cg_l_d    = cg_l_q;
    cg_r_d    = cg_r_q;
    p_l_d     = p_l_q;
    p_r_d     = p_r_q;
    l_out_d   = l_out_q;
    r_out_d   = r_out_q;
    valid_d   = 1'b0;
    clip_l_d  = clip_l_q & ~clip_clr;
    clip_r_d  = clip_r_q & ~clip_clr;
    overrun_d = overrun_q & ~clip_clr;

    case (state_q)
      ST_IDLE: begin
        if (aud.ena_in) begin
          l_in_d  = aud.l_in;
          r_in_d  = aud.r_in;
          cg_l_d  = ramp_toward(cg_l_q, tgt_l);
          cg_r_d  = ramp_toward(cg_r_q, tgt_r);
          state_d = ST_MUL_L;
        end
      end
      ST_MUL_L: begin
        p_l_d   = mul_p;
        state_d = ST_MUL_R;
      end
      ST_MUL_R: begin
        p_r_d   = mul_p;
        state_d = ST_SAT;
      end
      ST_SAT: begin
        l_out_d = sat_l_y;
        r_out_d = sat_r_y;
        valid_d = 1'b1;
        if (sat_l_clip) clip_l_d = 1'b1;
        if (sat_r_clip) clip_r_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe landing mid-sample is dropped; the set takes priority over clip_clr.
    if (aud.ena_in && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      l_in_q    <= '0;
      r_in_q    <= '0;
      cg_l_q    <= '0;
      cg_r_q    <= '0;
      p_l_q     <= '0;
      p_r_q     <= '0;
      l_out_q   <= '0;
      r_out_q   <= '0;
      valid_q   <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_in_q    <= l_in_d;
      r_in_q    <= r_in_d;
      cg_l_q    <= cg_l_d;
      cg_r_q    <= cg_r_d;
      p_l_q     <= p_l_d;
      p_r_q     <= p_r_d;
      l_out_q   <= l_out_d;
      r_out_q   <= r_out_d;
      valid_q   <= valid_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      overrun_q <= overrun_d;
    end
  end

  assign aud.l_out     = l_out_q;
  assign aud.r_out     = r_out_q;
  assign aud.valid_out = valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign clip_l        = clip_l_q;
  assign clip_r        = clip_r_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// Scoreboard bench for audio_gain_stage: directed strobes push expected
// outputs, an independent monitor pops them on every valid_out pulse.
module tb_audio_gain_stage;

  logic       clk;
  logic       reset;
  logic [7:0] gain_l;
  logic [7:0] gain_r;
  logic       mute;
  logic       clip_clr;
  logic       busy;
  logic       clip_l;
  logic       clip_r;
  logic       overrun;

  audio_gain_stage_if #(.DW(16)) aud ();

  audio_gain_stage #(.DW(16), .GW(8), .RAMP_STEP(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .aud      (aud),
    .gain_l   (gain_l),
    .gain_r   (gain_r),
    .mute     (mute),
    .clip_clr (clip_clr),
    .busy     (busy),
    .clip_l   (clip_l),
    .clip_r   (clip_r),
    .overrun  (overrun)
  );

  typedef struct {
    int l;
    int r;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   edge_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vec_cnt++;
    if (actual != expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called just after a rising edge; leaves the bench aligned the same way.
  task automatic applyStimulus(input int l, input int r, input int exp_l, input int exp_r);
    aud.l_in   = 16'(l);
    aud.r_in   = 16'(r);
    aud.ena_in = 1'b1;
    sb.push_back('{l: exp_l, r: exp_r, edge_n: edge_cnt + 1});
    @(posedge clk) #1;
    aud.ena_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Valid pulses register three edges after the sampling edge (4th clock counting the strobe clock).
  always @(negedge clk) begin
    if (aud.valid_out) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", aud.valid_out, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("l_out", aud.l_out, mon_e.l);
        checkOutput("r_out", aud.r_out, mon_e.r);
        checkOutput("latency", edge_cnt - mon_e.edge_n, 3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    gain_l     = 8'd128;
    gain_r     = 8'd128;
    mute       = 1'b0;
    clip_clr   = 1'b0;
    aud.ena_in = 1'b0;
    aud.l_in   = '0;
    aud.r_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", aud.valid_out, 0);
    checkOutput("reset_l_out", aud.l_out, 0);
    checkOutput("reset_r_out", aud.r_out, 0);
    checkOutput("reset_clip_l", clip_l, 0);
    checkOutput("reset_clip_r", clip_r, 0);
    checkOutput("reset_overrun", overrun, 0);
    reset = 1'b0;
    @(posedge clk) #1;

    // Startup ramp from silence: gain k/128 on the k-th sample.
    for (int k = 1; k <= 130; k++) begin
      applyStimulus(12800, -12800, 100 * ((k > 128) ? 128 : k), -100 * ((k > 128) ? 128 : k));
    end

    // Unity gain passes samples unchanged.
    applyStimulus(1000, -1000, 1000, -1000);
    applyStimulus(-7, 32767, -7, 32767);
    checkOutput("clip_l_unity", clip_l, 0);
    checkOutput("clip_r_unity", clip_r, 0);

    // Ramp to 255 on silence, then drive full scale into saturation.
    gain_l = 8'd255;
    gain_r = 8'd255;
    for (int k = 1; k <= 127; k++) applyStimulus(0, 0, 0, 0);
    applyStimulus(32767, -32768, 32767, -32768);
    checkOutput("clip_l_set", clip_l, 1);
    checkOutput("clip_r_set", clip_r, 1);
    applyStimulus(-300, 300, -598, 597);

    clip_clr = 1'b1;
    @(posedge clk) #1;
    clip_clr = 1'b0;
    checkOutput("clip_l_cleared", clip_l, 0);
    checkOutput("clip_r_cleared", clip_r, 0);

    // Strobe during MUL_R is dropped; clip_clr during a clipping SAT loses.
    aud.l_in   = 16'sd32767;
    aud.r_in   = -16'sd32768;
    aud.ena_in = 1'b1;
    sb.push_back('{l: 32767, r: -32768, edge_n: edge_cnt + 1});
    @(posedge clk) #1;
    aud.ena_in = 1'b0;
    @(posedge clk) #1;
    aud.ena_in = 1'b1;
    aud.l_in   = 16'sd5;
    aud.r_in   = 16'sd5;
    @(posedge clk) #1;
    aud.ena_in = 1'b0;
    checkOutput("overrun_set", overrun, 1);
    checkOutput("busy_in_sat", busy, 1);
    clip_clr = 1'b1;
    @(posedge clk) #1;
    clip_clr = 1'b0;
    checkOutput("clip_l_set_wins", clip_l, 1);
    checkOutput("clip_r_set_wins", clip_r, 1);
    checkOutput("overrun_cleared", overrun, 0);
    checkOutput("busy_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // Back to unity, then mute ramps down one step per sample and back up.
    gain_l = 8'd128;
    gain_r = 8'd128;
    for (int k = 1; k <= 127; k++) applyStimulus(0, 0, 0, 0);
    mute = 1'b1;
    for (int k = 1; k <= 128; k++) applyStimulus(12800, -12800, 100 * (128 - k), -100 * (128 - k));
    applyStimulus(12800, -12800, 0, 0);
    mute = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(12800, -12800, 100 * k, -100 * k);

    // Reset during MUL_R aborts the sample and restarts the ramp from zero.
    aud.l_in   = 16'sd12800;
    aud.r_in   = -16'sd12800;
    aud.ena_in = 1'b1;
    @(posedge clk) #1;
    aud.ena_in = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", aud.valid_out, 0);
    checkOutput("abort_l_out", aud.l_out, 0);
    checkOutput("abort_r_out", aud.r_out, 0);
    checkOutput("abort_clip_l", clip_l, 0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(12800, -12800, 100, -100);
    applyStimulus(12800, -12800, 200, -200);

    repeat (10) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
